// File: rtl/hello_cpu_0_jtag_debug_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : hello_cpu_0_jtag_debug_cmd_dispatch
// Brief    : Brings virtual-JTAG update-DR/update-IR levels into the clk
//            domain, captures the debug shift register on each update-DR and
//            issues a one-cycle, one-hot action / no-action strobe on the
//            channel selected by the last update-IR. Optionally holds off new
//            commands until the channel acknowledges; dropped commands set a
//            sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module hello_cpu_0_jtag_debug_cmd_dispatch #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 3,
    parameter int ACT_BIT     = 35,
    parameter int REQUIRE_ACK = 1,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vs_udr,
    input  logic                   vs_uir,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [SR_W-1:0]        sr,
    input  logic [(2**IR_W)-1:0]   act_ack,
    input  logic                   ovr_clr,
    output logic [SR_W-1:0]        jdo,
    output logic [(2**IR_W)-1:0]   take_action,
    output logic [(2**IR_W)-1:0]   take_no_action,
    output logic                   busy,
    output logic                   overrun,
    output logic [CNT_W-1:0]       cmd_count
);

    localparam int NUM_CH = 2**IR_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    // Synchroniser chains, delay flops and registered rising-edge pulses
    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_dly;
    logic                   r_uir_dly;
    logic                   r_udr_edge;
    logic                   r_uir_edge;

    state_t                 r_state;
    logic [IR_W-1:0]        r_ir;
    logic [IR_W-1:0]        r_ch;
    logic [SR_W-1:0]        r_jdo;
    logic [NUM_CH-1:0]      r_take_action;
    logic [NUM_CH-1:0]      r_take_no_action;
    logic                   r_overrun;
    logic [CNT_W-1:0]       r_cmd_count;

    // One-hot select for the channel held in the instruction register; this is
    // the channel a command accepted this cycle will be dispatched to.
    logic [NUM_CH-1:0]      w_sel_onehot;
    assign w_sel_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ir;

    // Bring the TCK-domain levels into clk and register their rising edges.
    // The edge pulse is registered so that the uir and udr edges seen in the
    // same cycle act together on the next edge, with ch taking the old ir.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_udr_sync <= '0;
            r_uir_sync <= '0;
            r_udr_dly  <= 1'b0;
            r_uir_dly  <= 1'b0;
            r_udr_edge <= 1'b0;
            r_uir_edge <= 1'b0;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
            r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
            r_udr_edge <= r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;
            r_uir_edge <= r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;
        end
    end

    // Command FSM with registered strobes, capture, counter and overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_ir             <= '0;
            r_ch             <= '0;
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_overrun        <= 1'b0;
            r_cmd_count      <= '0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;

            if (r_uir_edge) begin
                r_ir <= ir_in;
            end

            // Clear first so that a coincident new overrun below takes priority
            if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
            if (r_udr_edge && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_udr_edge) begin
                        r_jdo   <= sr;
                        r_ch    <= r_ir;
                        r_state <= S_ISSUE;
                        // sr is what jdo holds during ISSUE, so decode it now
                        if (sr[ACT_BIT]) begin
                            r_take_action <= w_sel_onehot;
                        end else begin
                            r_take_no_action <= w_sel_onehot;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cmd_count <= r_cmd_count + CNT_W'(1);
                    r_state     <= (REQUIRE_ACK != 0) ? S_WAIT_ACK : S_IDLE;
                end
                S_WAIT_ACK: begin
                    if (act_ack[r_ch]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign busy           = (r_state != S_IDLE);
    assign overrun        = r_overrun;
    assign cmd_count      = r_cmd_count;

endmodule
`default_nettype wire

// File: tb/tb_hello_cpu_0_jtag_debug_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_hello_cpu_0_jtag_debug_cmd_dispatch
// Brief    : Directed self-checking bench for the JTAG debug command
//            dispatcher. dut_a uses REQUIRE_ACK=1, dut_n uses REQUIRE_ACK=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hello_cpu_0_jtag_debug_cmd_dispatch;

    localparam int SR_W = 38;
    localparam int IR_W = 2;
    localparam int NCH  = 4;
    localparam int SYNC = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            vs_udr_a;
    logic            vs_udr_n;
    logic            vs_uir;
    logic [IR_W-1:0] ir_in;
    logic [SR_W-1:0] sr;
    logic [NCH-1:0]  act_ack;
    logic            ovr_clr;

    logic [SR_W-1:0] jdo_a, jdo_n;
    logic [NCH-1:0]  ta_a, tna_a, ta_n, tna_n;
    logic            busy_a, busy_n, ovr_a, ovr_n;
    logic [7:0]      cnt_a, cnt_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hello_cpu_0_jtag_debug_cmd_dispatch #(
        .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(SYNC), .ACT_BIT(35),
        .REQUIRE_ACK(1), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .vs_udr(vs_udr_a), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .act_ack(act_ack), .ovr_clr(ovr_clr),
        .jdo(jdo_a), .take_action(ta_a), .take_no_action(tna_a),
        .busy(busy_a), .overrun(ovr_a), .cmd_count(cnt_a)
    );

    hello_cpu_0_jtag_debug_cmd_dispatch #(
        .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(SYNC), .ACT_BIT(35),
        .REQUIRE_ACK(0), .CNT_W(8)
    ) dut_n (
        .clk(clk), .reset(reset), .vs_udr(vs_udr_n), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .act_ack(act_ack), .ovr_clr(ovr_clr),
        .jdo(jdo_n), .take_action(ta_n), .take_no_action(tna_n),
        .busy(busy_n), .overrun(ovr_n), .cmd_count(cnt_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Load the instruction register through a vs_uir pulse
    task automatic load_ir(input logic [IR_W-1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        step(6);
        vs_uir = 1'b0;
        step(4);
    endtask

    // Observe dut_a strobes over n cycles: OR of values and pulse count
    task automatic watch_a(input int n, output logic [NCH-1:0] ta_or,
                           output logic [NCH-1:0] tna_or, output int pulses);
        ta_or  = '0;
        tna_or = '0;
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            ta_or  = ta_or | ta_a;
            tna_or = tna_or | tna_a;
            if ((ta_a | tna_a) != '0) pulses++;
        end
    endtask

    logic [NCH-1:0] ta_or, tna_or;
    int             pulses;
    int             n_strobe_n;

    initial begin
        reset    = 1'b1;
        vs_udr_a = 1'b0;
        vs_udr_n = 1'b0;
        vs_uir   = 1'b0;
        ir_in    = '0;
        sr       = '0;
        act_ack  = '0;
        ovr_clr  = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);

        // Reset state
        check("rst_take_action", ta_a, 0);
        check("rst_take_no_action", tna_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_cmd_count", cnt_a, 0);
        check("rst_jdo", jdo_a, 0);

        // Action command on channel 2, latency SYNC+2 edges
        load_ir(2'd2);
        sr       = 38'h8_0000_1234;
        vs_udr_a = 1'b1;
        step(SYNC + 1);
        check("act_before_latency", ta_a, 0);
        step(1);
        check("act_strobe", ta_a, 4'b0100);
        check("act_no_action_clear", tna_a, 0);
        check("act_jdo", jdo_a, 38'h8_0000_1234);
        check("act_busy", busy_a, 1);
        step(1);
        check("act_strobe_one_cycle", ta_a, 0);
        // Level held high must not produce further commands
        watch_a(10, ta_or, tna_or, pulses);
        check("held_level_no_repeat", pulses, 0);
        vs_udr_a = 1'b0;
        step(4);
        check("act_wait_ack_busy", busy_a, 1);
        check("act_cmd_count", cnt_a, 1);
        act_ack = 4'b0100;
        step(1);
        act_ack = '0;
        check("act_ack_released", busy_a, 0);

        // No-action command on channel 2; ack on channel 0 is ignored
        sr       = 38'h0_0000_1234;
        vs_udr_a = 1'b1;
        step(SYNC + 2);
        check("noact_strobe", tna_a, 4'b0100);
        check("noact_action_clear", ta_a, 0);
        step(3);
        vs_udr_a = 1'b0;
        step(4);
        act_ack = 4'b0001;
        step(3);
        check("noact_other_ack_ignored", busy_a, 1);
        act_ack = '0;

        // Second command while waiting for ack is dropped and flags overrun
        sr       = 38'h3F_FFFF_FFFF;
        vs_udr_a = 1'b1;
        watch_a(9, ta_or, tna_or, pulses);
        check("drop_no_strobe", pulses, 0);
        vs_udr_a = 1'b0;
        step(4);
        check("drop_jdo_unchanged", jdo_a, 38'h0_0000_1234);
        check("drop_overrun_set", ovr_a, 1);
        act_ack = 4'b0100;
        step(1);
        act_ack = '0;
        check("drop_ack_released", busy_a, 0);
        check("drop_overrun_sticky", ovr_a, 1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check("ovr_clr", ovr_a, 0);
        check("drop_cmd_count", cnt_a, 2);

        // uir and udr in the same cycle: command uses the old channel (1)
        load_ir(2'd1);
        ir_in    = 2'd3;
        sr       = 38'h8_0000_00AA;
        vs_uir   = 1'b1;
        vs_udr_a = 1'b1;
        watch_a(9, ta_or, tna_or, pulses);
        check("same_cycle_old_channel", ta_or, 4'b0010);
        check("same_cycle_one_cmd", pulses, 1);
        vs_uir   = 1'b0;
        vs_udr_a = 1'b0;
        step(4);
        act_ack = 4'b0010;
        step(1);
        act_ack = '0;
        check("same_cycle_ack", busy_a, 0);
        vs_udr_a = 1'b1;
        watch_a(9, ta_or, tna_or, pulses);
        check("next_cmd_new_channel", ta_or, 4'b1000);
        vs_udr_a = 1'b0;
        step(4);
        act_ack = 4'b1000;
        step(1);
        act_ack = '0;
        check("next_cmd_ack", busy_a, 0);
        check("ch_cmd_count", cnt_a, 4);

        // Fire-and-forget: 256 commands wrap the 8-bit counter
        n_strobe_n = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) check("wrap_count_255", cnt_n, 255);
            vs_udr_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (ta_n != '0) n_strobe_n++;
            end
            vs_udr_n = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (ta_n != '0) n_strobe_n++;
            end
        end
        step(4);
        check("wrap_count_zero", cnt_n, 0);
        check("wrap_strobe_total", n_strobe_n, 256);
        check("noack_busy_idle", busy_n, 0);
        check("noack_no_overrun", ovr_n, 0);

        // Reset during ISSUE aborts the command immediately
        sr       = 38'h8_0000_0055;
        vs_udr_a = 1'b1;
        step(SYNC + 2);
        check("pre_reset_strobe", ta_a, 4'b1000);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_take_action", ta_a, 0);
        check("rst_mid_take_no_action", tna_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_jdo", jdo_a, 0);
        check("rst_mid_cmd_count", cnt_a, 0);
        step(3);
        reset = 1'b0;
        // vs_udr still high at release: exactly one command, on channel 0
        watch_a(15, ta_or, tna_or, pulses);
        check("post_reset_one_cmd", pulses, 1);
        check("post_reset_channel0", ta_or, 4'b0001);
        vs_udr_a = 1'b0;
        step(4);
        check("post_reset_cmd_count", cnt_a, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
